// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: pops the XMIT FIFO and serialises start/data/parity/stop
// on sTX, paced by the 16x baud enable; also drives LSR THRE/TEMT.
module uart_tx_ctrl #(
   parameter int PDATA_WIDTH        = 8,
   parameter int BAUD_SAMPLE_CYCLES = 16
) (
   input  logic                   PCLK,
   input  logic                   PRESET,
   input  logic                   baud16_tick,
   input  logic                   fifo_empty,
   output logic                   fifo_rd,
   input  logic [PDATA_WIDTH-1:0] fifo_rdata,
   input  logic [1:0]             lcr_wls,
   input  logic                   lcr_stb,
   input  logic                   lcr_pen,
   input  logic                   lcr_eps,
   input  logic                   lcr_bc,
   input  logic                   mcr_loop,
   output logic                   sTX,
   output logic                   loop_tx,
   output logic                   thre,
   output logic                   temt,
   output logic                   tx_busy
);

   localparam int TW = $clog2(2 * BAUD_SAMPLE_CYCLES);
   localparam int BW = $clog2(PDATA_WIDTH);
   localparam logic [TW-1:0] BIT_LAST   = TW'(BAUD_SAMPLE_CYCLES - 1);
   localparam logic [TW-1:0] STOP15_LAST = TW'(BAUD_SAMPLE_CYCLES + BAUD_SAMPLE_CYCLES / 2 - 1);
   localparam logic [TW-1:0] STOP2_LAST  = TW'(2 * BAUD_SAMPLE_CYCLES - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP} state_e;

   state_e                 state_q;
   logic [PDATA_WIDTH-1:0] shreg_q;
   logic [TW-1:0]          tick_q;
   logic [BW-1:0]          bit_q;
   logic [1:0]             wls_q;
   logic                   stb_q, pen_q, par_q, frame_q;
   logic                   bc_q, loop_q, thre_q, temt_q;

   logic [PDATA_WIDTH-1:0] char_mask;
   logic                   par_d;
   logic [TW-1:0]          last_tick;
   logic                   tick_end, data_last, pop;

   // Parity is taken from the N live data bits only, at load time.
   always_comb begin
      char_mask = '0;
      for (int i = 0; i < PDATA_WIDTH; i++)
         char_mask[i] = (i < 5 + int'(lcr_wls));
      par_d = ^(fifo_rdata & char_mask) ^ ~lcr_eps;
   end

   always_comb begin
      last_tick = BIT_LAST;
      if (state_q == S_STOP && stb_q)
         last_tick = (wls_q == 2'b00) ? STOP15_LAST : STOP2_LAST;
   end

   assign tick_end  = baud16_tick && (tick_q == last_tick);
   assign data_last = (bit_q == BW'(wls_q) + BW'(4));

   // Pop is combinational so a back-to-back frame starts 2 cycles after the terminal stop tick.
   assign pop = !PRESET && !fifo_empty &&
                (state_q == S_IDLE || (state_q == S_STOP && tick_end));
   assign fifo_rd = pop;

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q <= S_IDLE;
         shreg_q <= '0;
         tick_q  <= '0;
         bit_q   <= '0;
         wls_q   <= '0;
         stb_q   <= 1'b0;
         pen_q   <= 1'b0;
         par_q   <= 1'b0;
         frame_q <= 1'b1;
         bc_q    <= 1'b0;
         loop_q  <= 1'b0;
         thre_q  <= 1'b1;
         temt_q  <= 1'b1;
      end else begin
         bc_q   <= lcr_bc;
         loop_q <= mcr_loop;
         thre_q <= fifo_empty;
         temt_q <= fifo_empty && (state_q == S_IDLE);
         if (baud16_tick && state_q != S_IDLE && state_q != S_LOAD)
            tick_q <= tick_end ? '0 : tick_q + 1'b1;
         case (state_q)
            S_IDLE: if (pop) state_q <= S_LOAD;
            S_LOAD: begin
               shreg_q <= fifo_rdata;
               wls_q   <= lcr_wls;
               stb_q   <= lcr_stb;
               pen_q   <= lcr_pen;
               par_q   <= par_d;
               tick_q  <= '0;
               bit_q   <= '0;
               frame_q <= 1'b0;
               state_q <= S_START;
            end
            S_START: if (tick_end) begin
               frame_q <= shreg_q[0];
               state_q <= S_DATA;
            end
            S_DATA: if (tick_end) begin
               if (data_last) begin
                  frame_q <= pen_q ? par_q : 1'b1;
                  state_q <= pen_q ? S_PARITY : S_STOP;
               end else begin
                  bit_q   <= bit_q + 1'b1;
                  shreg_q <= shreg_q >> 1;
                  frame_q <= shreg_q[1];
               end
            end
            S_PARITY: if (tick_end) begin
               frame_q <= 1'b1;
               state_q <= S_STOP;
            end
            S_STOP: if (tick_end) state_q <= pop ? S_LOAD : S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Break and loopback only steer the pin; the sequencer keeps running underneath.
   assign sTX     = bc_q ? 1'b0 : (loop_q ? 1'b1 : frame_q);
   assign loop_tx = loop_q ? frame_q : 1'b1;
   assign thre    = thre_q;
   assign temt    = temt_q;
   assign tx_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Randomised bench for uart_tx_ctrl: a cycle-level frame model built from
// (value, tick-length) bit lists predicts every output each cycle.
module tb_uart_tx_ctrl;

   logic       PCLK = 1'b0;
   logic       PRESET = 1'b1;
   logic       baud16_tick = 1'b0;
   logic       fifo_empty = 1'b1;
   logic       fifo_rd;
   logic [7:0] fifo_rdata = 8'h00;
   logic [1:0] lcr_wls = 2'b11;
   logic       lcr_stb = 1'b0, lcr_pen = 1'b0, lcr_eps = 1'b0, lcr_bc = 1'b0, mcr_loop = 1'b0;
   logic       sTX, loop_tx, thre, temt, tx_busy;

   always #5 PCLK = ~PCLK;

   uart_tx_ctrl #(.PDATA_WIDTH(8), .BAUD_SAMPLE_CYCLES(16)) dut (
      .PCLK(PCLK), .PRESET(PRESET), .baud16_tick(baud16_tick),
      .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .fifo_rdata(fifo_rdata),
      .lcr_wls(lcr_wls), .lcr_stb(lcr_stb), .lcr_pen(lcr_pen), .lcr_eps(lcr_eps),
      .lcr_bc(lcr_bc), .mcr_loop(mcr_loop),
      .sTX(sTX), .loop_tx(loop_tx), .thre(thre), .temt(temt), .tx_busy(tx_busy)
   );

   int           n_chk = 0, n_err = 0;
   byte unsigned fq[$];
   int           tick_per = 4, tick_ctr = 0, npop = 0;
   bit           chk_en = 1'b0;

   // Reference model: the frame as a list of line values and their lengths in ticks.
   bit           m_load = 1'b0, m_act = 1'b0;
   bit           m_bits[$];
   int           m_dur[$];
   int           m_idx = 0, m_rem = 0;
   bit           m_bcq = 1'b0, m_lpq = 1'b0, m_thre = 1'b1, m_temt = 1'b1;
   byte unsigned m_char = 8'h00;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, obs, exp);
      end
   endtask

   function automatic void build(input byte unsigned c, input logic [1:0] wls,
                                 input logic stb, input logic pen, input logic eps);
      int n;
      bit p;
      n = 5 + int'(wls);
      p = 1'b0;
      m_bits.delete();
      m_dur.delete();
      m_bits.push_back(1'b0); m_dur.push_back(16);
      for (int i = 0; i < n; i++) begin
         m_bits.push_back(c[i]); m_dur.push_back(16);
         p ^= c[i];
      end
      if (pen) begin
         m_bits.push_back(eps ? p : !p); m_dur.push_back(16);
      end
      m_bits.push_back(1'b1);
      m_dur.push_back(!stb ? 16 : (wls == 2'b00 ? 24 : 32));
   endfunction

   task automatic cyc();
      bit busy, line, last, erd, rd_s, emp, rst;
      @(negedge PCLK);
      tick_ctr++;
      baud16_tick = (tick_per == 0) ? ($urandom_range(0, 2) == 0) : (tick_ctr % tick_per == 0);
      #1;
      emp  = fifo_empty;
      rst  = PRESET;
      busy = m_load || m_act;
      line = m_act ? m_bits[m_idx] : 1'b1;
      last = m_act && baud16_tick && (m_idx == m_bits.size() - 1) && (m_rem == 1);
      erd  = !rst && !emp && ((!m_load && !m_act) || last);
      if (chk_en) begin
         chk("sTX", sTX, m_bcq ? 1'b0 : (m_lpq ? 1'b1 : line));
         chk("loop_tx", loop_tx, m_lpq ? line : 1'b1);
         chk("fifo_rd", fifo_rd, erd);
         chk("tx_busy", tx_busy, busy);
         chk("thre", thre, m_thre);
         chk("temt", temt, m_temt);
      end
      m_thre = rst || emp;
      m_temt = rst || (emp && !busy);
      m_bcq  = !rst && lcr_bc;
      m_lpq  = !rst && mcr_loop;
      if (rst) begin
         m_load = 1'b0;
         m_act  = 1'b0;
      end else begin
         if (m_act && baud16_tick) begin
            m_rem--;
            if (m_rem == 0) begin
               m_idx++;
               if (m_idx == m_bits.size()) m_act = 1'b0;
               else m_rem = m_dur[m_idx];
            end
         end
         if (m_load) begin
            build(m_char, lcr_wls, lcr_stb, lcr_pen, lcr_eps);
            m_act  = 1'b1;
            m_idx  = 0;
            m_rem  = m_dur[0];
            m_load = 1'b0;
         end
         if (erd) begin
            m_char = fq[0];
            m_load = 1'b1;
         end
      end
      rd_s = fifo_rd;
      @(posedge PCLK);
      #1;
      if (rd_s === 1'b1) begin
         npop++;
         if (fq.size() > 0) fifo_rdata = fq.pop_front();
      end
      fifo_empty = (fq.size() == 0);
   endtask

   task automatic push(input byte unsigned c);
      fq.push_back(c);
      fifo_empty = 1'b0;
   endtask

   task automatic drain();
      int n;
      bit idle;
      n = 0;
      while ((m_load || m_act || fq.size() != 0) && n < 20000) begin
         cyc();
         n++;
      end
      idle = !(m_load || m_act || fq.size() != 0);
      chk("drain_idle", idle, 1'b1);
      repeat (4) cyc();
   endtask

   task automatic run_to(input int b);
      int n;
      n = 0;
      while (!(m_act && m_idx == b) && n < 5000) begin
         cyc();
         n++;
      end
      chk("reach_bit", (m_act && m_idx == b), 1'b1);
   endtask

   task automatic set_lcr(input logic [1:0] wls, input logic pen, input logic eps, input logic stb);
      lcr_wls = wls; lcr_pen = pen; lcr_eps = eps; lcr_stb = stb;
   endtask

   initial begin
      int p0;
      cyc();
      chk_en = 1'b1;
      cyc();
      chk("rst_sTX", sTX, 1'b1);
      chk("rst_loop_tx", loop_tx, 1'b1);
      chk("rst_thre", thre, 1'b1);
      chk("rst_temt", temt, 1'b1);
      chk("rst_busy", tx_busy, 1'b0);
      PRESET = 1'b0;
      cyc();

      // 8N1 0xA5, tick every 4 cycles
      tick_per = 4;
      set_lcr(2'b11, 1'b0, 1'b0, 1'b0);
      p0 = npop; push(8'hA5); drain();
      chk("8n1_npop", npop - p0, 1);

      // 5E1.5 with upper bits set
      set_lcr(2'b00, 1'b1, 1'b1, 1'b1);
      p0 = npop; push(8'hFF); drain();
      chk("5e15_npop", npop - p0, 1);

      // 7O2 0x40
      tick_per = 3;
      set_lcr(2'b10, 1'b1, 1'b0, 1'b1);
      p0 = npop; push(8'h40); drain();
      chk("7o2_npop", npop - p0, 1);

      // back-to-back
      tick_per = 2;
      set_lcr(2'b11, 1'b0, 1'b0, 1'b0);
      p0 = npop; push(8'h55); push(8'h0F); drain();
      chk("b2b_npop", npop - p0, 2);

      // break mid-DATA, then loopback
      p0 = npop; push(8'h96); run_to(4);
      lcr_bc = 1'b1; repeat (40) cyc(); lcr_bc = 1'b0;
      drain();
      mcr_loop = 1'b1; push(8'h3C); drain(); mcr_loop = 1'b0; cyc();
      chk("brk_lb_npop", npop - p0, 2);

      // reset during parity bit
      set_lcr(2'b10, 1'b1, 1'b1, 1'b0);
      p0 = npop; push(8'h5A); run_to(8);
      repeat (3) cyc();
      PRESET = 1'b1; cyc(); PRESET = 1'b0;
      repeat (30) cyc();
      chk("rst_mid_npop", npop - p0, 1);

      // wls change mid-frame only affects the next frame
      set_lcr(2'b11, 1'b0, 1'b0, 1'b0);
      p0 = npop; push(8'hC3); push(8'h3C); run_to(3);
      set_lcr(2'b00, 1'b1, 1'b0, 1'b0);
      drain();
      chk("lcr_chg_npop", npop - p0, 2);

      // random traffic
      for (int blk = 0; blk < 6; blk++) begin
         tick_per = $urandom_range(0, 5);
         for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 149) == 0 && fq.size() < 4) push(8'($urandom()));
            if ($urandom_range(0, 299) == 0)
               set_lcr(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 399) == 0) lcr_bc = ~lcr_bc;
            if ($urandom_range(0, 399) == 0) mcr_loop = ~mcr_loop;
            if ($urandom_range(0, 999) == 0) begin
               PRESET = 1'b1; cyc(); PRESET = 1'b0;
            end
            cyc();
         end
         lcr_bc = 1'b0;
         mcr_loop = 1'b0;
         drain();
      end

      $display("[TB] %0d tests run, %0d failed", n_chk, n_err);
      $finish;
   end

endmodule
